// File: rtl/cpu_mem_access.sv
// MEM-stage data access unit: runs one req/ack bus transaction per memory
// instruction, stalls the pipeline while it is outstanding, aligns/merges
// load data, owns the LL/SC link bit and reports bus timeouts.

package cpu_mem_access_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_LWL, OP_LWR,
    OP_SB, OP_SH, OP_SW, OP_SC, OP_SWL, OP_SWR
  } Oper_t;

  typedef struct packed {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } MemAccessReq_t;
endpackage

module cpu_mem_access
  import cpu_mem_access_pkg::*;
#(
  parameter int BUS_TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  Oper_t         op,
  input  MemAccessReq_t mem_req,
  input  logic [31:0]   reg2,
  input  logic          except_occur,
  input  logic          flush,
  input  logic          llbit_set,
  input  logic          llbit_clr,
  output logic          bus_req,
  output logic          bus_we,
  output logic [31:0]   bus_addr,
  output logic [3:0]    bus_sel,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata,
  output logic [31:0]   load_data,
  output logic          llbit,
  output logic          bus_err,
  output logic          stall_req
);

  localparam int CW = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;

  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  logic        bus_req_reg, bus_we_reg, bus_err_reg, llbit_reg;
  logic [31:0] bus_addr_reg, bus_wdata_reg, load_data_reg;
  logic [3:0]  bus_sel_reg;

  logic        need, sc_fail, timeout_hit;
  logic [31:0] m, aligned;
  logic [7:0]  rbyte [4];
  logic [7:0]  bsel;
  logic [15:0] hsel;

  // A failing SC (link already broken) never touches the bus.
  assign need        = mem_req.ce & ~except_occur & ~flush & ~((op == OP_SC) & ~llbit_reg);
  assign sc_fail     = (state_reg == IDLE) & mem_req.ce & ~except_occur & ~flush
                       & (op == OP_SC) & ~llbit_reg;
  assign timeout_hit = (cnt_reg == CW'(BUS_TIMEOUT - 1));

  // Combinational so EX/MEM freezes in the very cycle the request appears.
  assign stall_req = (need & ((state_reg == IDLE) | (state_reg == BUSY)))
                   | ((state_reg == ABORT) & mem_req.ce);

  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_sel   = bus_sel_reg;
  assign bus_wdata = bus_wdata_reg;
  assign bus_err   = bus_err_reg;
  assign llbit     = llbit_reg;
  // The failed-SC result must be visible in the same cycle since nothing stalls.
  assign load_data = sc_fail ? 32'd0 : load_data_reg;

  // Read data is forced to zero when leaving BUSY through the timeout path.
  assign m = bus_ack ? bus_rdata : 32'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign rbyte[gi] = m[8*gi +: 8];
    end
  endgenerate

  // Next-state logic; ABORT waits out the bus transaction (or its timeout).
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (need) state_next = BUSY;
      BUSY: begin
        if (flush)                      state_next = bus_ack ? IDLE : ABORT;
        else if (bus_ack | timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      ABORT:   if (bus_ack | timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load alignment / merge of the returned word (little-endian byte lanes).
  always_comb begin
    aligned = 32'd0;
    bsel    = rbyte[mem_req.addr[1:0]];
    hsel    = mem_req.addr[1] ? m[31:16] : m[15:0];
    case (op)
      OP_LB:  aligned = {{24{bsel[7]}}, bsel};
      OP_LBU: aligned = {24'd0, bsel};
      OP_LH:  aligned = {{16{hsel[15]}}, hsel};
      OP_LHU: aligned = {16'd0, hsel};
      OP_LW, OP_LL: aligned = m;
      OP_LWL: begin
        case (mem_req.addr[1:0])
          2'd0:    aligned = {m[7:0],  reg2[23:0]};
          2'd1:    aligned = {m[15:0], reg2[15:0]};
          2'd2:    aligned = {m[23:0], reg2[7:0]};
          default: aligned = m;
        endcase
      end
      OP_LWR: begin
        case (mem_req.addr[1:0])
          2'd0:    aligned = m;
          2'd1:    aligned = {reg2[31:24], m[31:8]};
          2'd2:    aligned = {reg2[31:16], m[31:16]};
          default: aligned = {reg2[31:8],  m[31:24]};
        endcase
      end
      OP_SC:   aligned = {31'd0, bus_ack};
      default: aligned = 32'd0;
    endcase
  end

  // State register and wait counter; the counter measures time spent in the current wait state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == state_next) && ((state_reg == BUSY) || (state_reg == ABORT)))
        cnt_reg <= cnt_reg + CW'(1);
      else
        cnt_reg <= '0;
    end
  end

  // Bus request registers, result capture and the timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= 32'd0;
      bus_sel_reg   <= 4'd0;
      bus_wdata_reg <= 32'd0;
      load_data_reg <= 32'd0;
      bus_err_reg   <= 1'b0;
    end else begin
      bus_req_reg <= (state_next == BUSY) || (state_next == ABORT);
      bus_err_reg <= (state_reg == BUSY) && (state_next == DONE) && !bus_ack;
      if ((state_reg == IDLE) && need) begin
        bus_we_reg    <= mem_req.we;
        bus_addr_reg  <= {mem_req.addr[31:2], 2'b00};
        bus_sel_reg   <= mem_req.sel;
        bus_wdata_reg <= mem_req.wdata;
      end
      if (sc_fail)
        load_data_reg <= 32'd0;
      else if ((state_reg == BUSY) && (state_next == DONE))
        load_data_reg <= aligned;
    end
  end

  // Link bit: clear wins over set when both happen in one cycle.
  always_ff @(posedge clk) begin
    if (rst)
      llbit_reg <= 1'b0;
    else if (llbit_clr || ((state_reg == DONE) && (op == OP_SC)))
      llbit_reg <= 1'b0;
    else if ((state_reg == DONE) && llbit_set)
      llbit_reg <= 1'b1;
  end

endmodule

// File: tb/tb_cpu_mem_access.sv
// Scoreboard bench for cpu_mem_access: the driver pushes the expected result
// of each instruction, the monitor pops it when the instruction leaves MEM.
module tb_cpu_mem_access;
  import cpu_mem_access_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  Oper_t         op;
  MemAccessReq_t mem_req;
  logic [31:0]   reg2;
  logic          except_occur, flush, llbit_set, llbit_clr;
  logic          bus_req, bus_we, bus_err, stall_req, llbit;
  logic [31:0]   bus_addr, bus_wdata, load_data;
  logic [3:0]    bus_sel;
  logic          bus_ack = 1'b0;
  logic [31:0]   bus_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] ld;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // bus responder configuration (written by the driver between transactions)
  int          ack_wait = 0;
  logic        no_ack = 1'b0;
  logic [31:0] rdata_cfg = 32'd0;
  int          wait_cnt = 0;

  // bus snoop
  logic        last_we = 1'b0;
  logic [31:0] last_addr = 32'd0, last_wdata = 32'd0;
  logic [3:0]  last_sel = 4'd0;
  int          req_cycles = 0;
  int          err_cycles = 0;

  cpu_mem_access #(.BUS_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_req(mem_req), .reg2(reg2),
    .except_occur(except_occur), .flush(flush), .llbit_set(llbit_set),
    .llbit_clr(llbit_clr), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .load_data(load_data),
    .llbit(llbit), .bus_err(bus_err), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check32({tag, "_ctrl"}, {27'd0, bus_req, bus_we, bus_err, stall_req, llbit}, 32'd0);
    check32({tag, "_bus_addr"}, bus_addr, 32'd0);
    check32({tag, "_bus_sel"}, {28'd0, bus_sel}, 32'd0);
    check32({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    check32({tag, "_load_data"}, load_data, 32'd0);
  endtask

  // Bus slave: ack after ack_wait cycles of bus_req, inputs changed 1 after the edge.
  always @(posedge clk) begin
    #1;
    bus_ack = 1'b0;
    if (bus_req && !no_ack) begin
      if (wait_cnt >= ack_wait) begin
        bus_ack   = 1'b1;
        bus_rdata = rdata_cfg;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Snoop bus activity on the falling edge.
  always @(negedge clk) begin
    if (bus_req) begin
      last_we    = bus_we;
      last_addr  = bus_addr;
      last_sel   = bus_sel;
      last_wdata = bus_wdata;
      req_cycles++;
    end
    if (bus_err) err_cycles++;
  end

  // Monitor: an instruction leaves MEM when it is live and not stalled.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && mem_req.ce && !except_occur && !flush && !stall_req) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got load_data %h expected no completion", load_data);
      end else begin
        e = sb.pop_front();
        check32({e.name, "_load_data"}, load_data, e.ld);
        check32({e.name, "_bus_err"}, {31'd0, bus_err}, {31'd0, e.err});
        $display("xact %s load_data=%h bus_err=%0b", e.name, load_data, bus_err);
      end
    end
  end

  // Issue one instruction into MEM and hold it until the stall releases.
  task automatic xact(input string name, input Oper_t o, input logic we,
                      input logic [31:0] addr, input logic [3:0] sel,
                      input logic [31:0] wd, input logic [31:0] r2, input int aw,
                      input logic [31:0] rd, input logic push,
                      input logic [31:0] exp_ld, input logic exp_err, input int exp_stall);
    int   n;
    logic fin;
    exp_t e;
    op            = o;
    mem_req.ce    = 1'b1;
    mem_req.we    = we;
    mem_req.addr  = addr;
    mem_req.sel   = sel;
    mem_req.wdata = wd;
    reg2          = r2;
    ack_wait      = aw;
    rdata_cfg     = rd;
    llbit_set     = (o == OP_LL);
    if (push) begin
      e.name = name;
      e.ld   = exp_ld;
      e.err  = exp_err;
      sb.push_back(e);
    end
    n   = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (!stall_req) fin = 1'b1;
      else begin
        n++;
        if (n > 200) begin
          fin = 1'b1;
          checks++;
          errors++;
          $display("FAIL %s_stall_bound: got stall beyond 200 cycles expected release", name);
        end
      end
    end
    check32({name, "_stall_cycles"}, n, exp_stall);
    @(posedge clk);
    #1;
    mem_req.ce = 1'b0;
    llbit_set  = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int          r0, e0, n;
    logic [31:0] ld_before;
    rst          = 1'b1;
    op           = OP_NOP;
    mem_req      = '0;
    reg2         = 32'd0;
    except_occur = 1'b0;
    flush        = 1'b0;
    llbit_set    = 1'b0;
    llbit_clr    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    //   name      op      we    addr          sel   wdata         reg2          aw rdata         push exp_ld        err stall
    xact("lb",     OP_LB,  1'b0, 32'h0000_1003, 4'h8, 32'd0,        32'd0,        0, 32'h80FF_FF00, 1'b1, 32'hFFFF_FF80, 1'b0, 2);
    check32("lb_bus_addr", last_addr, 32'h0000_1000);
    xact("lwl",    OP_LWL, 1'b0, 32'h0000_2001, 4'hF, 32'd0,        32'hAABB_CCDD, 1, 32'h1122_3344, 1'b1, 32'h3344_CCDD, 1'b0, 3);
    xact("lwr",    OP_LWR, 1'b0, 32'h0000_2001, 4'hF, 32'd0,        32'hAABB_CCDD, 0, 32'h1122_3344, 1'b1, 32'hAA11_2233, 1'b0, 2);
    xact("lwr_o3", OP_LWR, 1'b0, 32'h0000_2003, 4'hF, 32'd0,        32'hAABB_CCDD, 0, 32'h1122_3344, 1'b1, 32'hAABB_CC11, 1'b0, 2);
    xact("lh",     OP_LH,  1'b0, 32'h0000_2002, 4'hC, 32'd0,        32'd0,        0, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001, 1'b0, 2);
    xact("lhu",    OP_LHU, 1'b0, 32'h0000_2000, 4'h3, 32'd0,        32'd0,        0, 32'h8001_7FFF, 1'b1, 32'h0000_7FFF, 1'b0, 2);
    xact("lbu",    OP_LBU, 1'b0, 32'h0000_2001, 4'h2, 32'd0,        32'd0,        0, 32'h1122_3344, 1'b1, 32'h0000_0033, 1'b0, 2);
    xact("lw",     OP_LW,  1'b0, 32'h0000_2004, 4'hF, 32'd0,        32'd0,        2, 32'h0F0E_0D0C, 1'b1, 32'h0F0E_0D0C, 1'b0, 4);
    xact("sw",     OP_SW,  1'b1, 32'h0000_5004, 4'hC, 32'hCAFE_F00D, 32'd0,        0, 32'hFFFF_FFFF, 1'b1, 32'd0,         1'b0, 2);
    check32("sw_bus_we", {31'd0, last_we}, 32'd1);
    check32("sw_bus_wdata", last_wdata, 32'hCAFE_F00D);
    check32("sw_bus_sel", {28'd0, last_sel}, 32'h0000_000C);
    xact("ll",     OP_LL,  1'b0, 32'h0000_3000, 4'hF, 32'd0,        32'd0,        0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0, 2);
    check32("ll_llbit", {31'd0, llbit}, 32'd1);

    // Flush in the second BUSY cycle; the bus acks three cycles later.
    ld_before     = 32'hDEAD_BEEF;
    r0            = req_cycles;
    op            = OP_LW;
    mem_req.ce    = 1'b1;
    mem_req.we    = 1'b0;
    mem_req.addr  = 32'h0000_4000;
    mem_req.sel   = 4'hF;
    ack_wait      = 4;
    rdata_cfg     = 32'h9999_9999;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush      = 1'b0;
    mem_req.ce = 1'b0;
    n = 0;
    while (bus_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check32("abort_bus_req_cycles", req_cycles - r0, 32'd5);
    check32("abort_load_data", load_data, ld_before);
    check32("abort_llbit", {31'd0, llbit}, 32'd1);
    @(posedge clk); #1;

    xact("lw_post_abort", OP_LW, 1'b0, 32'h0000_4000, 4'hF, 32'd0, 32'd0, 0, 32'h0BAD_CAFE, 1'b1, 32'h0BAD_CAFE, 1'b0, 2);
    check32("post_abort_llbit", {31'd0, llbit}, 32'd1);
    xact("sc_ok",  OP_SC,  1'b1, 32'h0000_3000, 4'hF, 32'h0000_0055, 32'd0, 0, 32'h1234_5678, 1'b1, 32'd1, 1'b0, 2);
    check32("sc_ok_bus_we", {31'd0, last_we}, 32'd1);
    check32("sc_ok_llbit", {31'd0, llbit}, 32'd0);
    r0 = req_cycles;
    xact("sc_fail", OP_SC, 1'b1, 32'h0000_3000, 4'hF, 32'h0000_0066, 32'd0, 0, 32'h1234_5678, 1'b1, 32'd0, 1'b0, 0);
    check32("sc_fail_bus_req_cycles", req_cycles - r0, 32'd0);

    // Bus never acks: 8 request cycles, one error pulse, read data forced to zero.
    no_ack = 1'b1;
    r0 = req_cycles;
    e0 = err_cycles;
    xact("timeout", OP_LW, 1'b0, 32'h0000_7000, 4'hF, 32'd0, 32'd0, 0, 32'h5555_AAAA, 1'b1, 32'd0, 1'b1, 9);
    no_ack = 1'b0;
    check32("timeout_bus_req_cycles", req_cycles - r0, 32'd8);
    check32("timeout_err_pulses", err_cycles - e0, 32'd1);

    except_occur = 1'b1;
    r0 = req_cycles;
    xact("except_sw", OP_SW, 1'b1, 32'h0000_7004, 4'hF, 32'h1111_2222, 32'd0, 0, 32'd0, 1'b0, 32'd0, 1'b0, 0);
    except_occur = 1'b0;
    check32("except_bus_req_cycles", req_cycles - r0, 32'd0);

    // Set and clear of the link bit in the same cycle resolve to clear.
    llbit_clr = 1'b1;
    xact("ll_clr", OP_LL, 1'b0, 32'h0000_6000, 4'hF, 32'd0, 32'd0, 0, 32'h0000_600D, 1'b1, 32'h0000_600D, 1'b0, 2);
    llbit_clr = 1'b0;
    check32("ll_clr_llbit", {31'd0, llbit}, 32'd0);
    xact("ll2", OP_LL, 1'b0, 32'h0000_6004, 4'hF, 32'd0, 32'd0, 1, 32'h1234_ABCD, 1'b1, 32'h1234_ABCD, 1'b0, 3);
    check32("ll2_llbit", {31'd0, llbit}, 32'd1);

    // Reset in the middle of a long access.
    op           = OP_LW;
    mem_req.ce   = 1'b1;
    mem_req.we   = 1'b0;
    mem_req.addr = 32'h0000_8008;
    mem_req.sel  = 4'hF;
    ack_wait     = 20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst        = 1'b1;
    mem_req.ce = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("rst_mid_busy");
    @(posedge clk); #1;
    rst      = 1'b0;
    ack_wait = 0;
    repeat (2) @(posedge clk);

    check32("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
